// File: rtl/serial_sub_if.sv
// Start/done handshake bundle for serial_sub.
// SERIAL_SUB_OVF_EN adds the registered signed-overflow flag ovf.
interface serial_sub_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, bin, input busy, done, d, bout, ovf);
    modport slave  (input start, a, b, bin, output busy, done, d, bout, ovf);
`else
    modport master (output start, a, b, bin, input busy, done, d, bout);
    modport slave  (input start, a, b, bin, output busy, done, d, bout);
`endif
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor d = a - b - bin, one bit per clock, LSB first.
// SERIAL_SUB_OVF_EN adds a registered two's-complement overflow output.
module serial_sub #(
    parameter int unsigned  WIDTH = 4,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic        clk,
    input  logic        rst,
    serial_sub_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             busy, done;
    logic             ai, bi, di, br_nx, last;

    always_comb begin
        ai    = a_q[0];
        bi    = b_q[0];
        di    = ai ^ bi ^ br_q;
        br_nx = (~ai & bi) | (~(ai ^ bi) & br_q);
        last  = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StRun;
            StRun:   if (last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == StRun);
        done = (state_q == StDone);
    end

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        res_d  = res_q;
        cnt_d  = cnt_q;
        br_d   = br_q;
        d_d    = d_q;
        bout_d = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d  = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d   = bus.a;
                    b_d   = bus.b;
                    br_d  = bus.bin;
                    cnt_d = '0;
                end
            end
            StRun: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_nx;
                res_d = {di, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    d_d    = {di, res_q[WIDTH-1:1]};
                    bout_d = br_nx;
`ifdef SERIAL_SUB_OVF_EN
                    // br_q is the borrow entering the MSB stage on this edge
                    ovf_d  = br_q ^ br_nx;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            cnt_q  <= '0;
            br_q   <= 1'b0;
            d_q    <= '0;
            bout_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            res_q  <= res_d;
            cnt_q  <= cnt_d;
            br_q   <= br_d;
            d_q    <= d_d;
            bout_q <= bout_d;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.d    = d_q;
    assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed, random, abort and back-to-back scenarios.
module tb_serial_sub;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   cyc = 0;
    int   prev_d = 0;

    serial_sub_if #(.WIDTH(W)) bus ();

    serial_sub #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
        $fatal(1, "timeout");
    end

    function automatic int model_d(input int a, input int b, input int bin);
        return (a - b - bin) & MASK;
    endfunction

    function automatic int model_bout(input int a, input int b, input int bin);
        return (a < b + bin) ? 1 : 0;
    endfunction

    function automatic int model_ovf(input int a, input int b, input int bin);
        int sa, sb, r;
        sa = (a > MASK / 2) ? a - (MASK + 1) : a;
        sb = (b > MASK / 2) ? b - (MASK + 1) : b;
        r  = sa - sb - bin;
        return (r < -(MASK + 1) / 2 || r > MASK / 2) ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drive a one-cycle start pulse; returns just after the accepting edge.
    task automatic issue(input int a, input int b, input int bin);
        bus.a     = a[W-1:0];
        bus.b     = b[W-1:0];
        bus.bin   = bin[0];
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.done === 1'b1) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.a = 4'hF;
        bus.b = 4'h1;
        bus.bin = 1'b0;
        tick();
        tick();
        tests_run += 4;
        if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", bus.done); end
        if (bus.d !== 4'h0) begin tests_failed++; $display("FAIL reset_d got %h want 0", bus.d); end
        if (bus.bout !== 1'b0) begin tests_failed++; $display("FAIL reset_bout got %b want 0", bus.bout); end
        bus.start = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        issue(9, 3, 0);
        for (int k = 0; k < W; k++) begin
            tests_run += 3;
            if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL lat_busy cycle %0d got %b want 1", k, bus.busy); end
            if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL lat_done_early cycle %0d got %b want 0", k, bus.done); end
            if (bus.d !== prev_d[W-1:0]) begin tests_failed++; $display("FAIL lat_d_hold cycle %0d got %h want %h", k, bus.d, prev_d[W-1:0]); end
            tick();
        end
        tests_run += 4;
        if (bus.done !== 1'b1) begin tests_failed++; $display("FAIL lat_done got %b want 1", bus.done); end
        if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL lat_busy_end got %b want 0", bus.busy); end
        if (bus.d !== 4'h6) begin tests_failed++; $display("FAIL lat_d got %h want 6", bus.d); end
        if (bus.bout !== 1'b0) begin tests_failed++; $display("FAIL lat_bout got %b want 0", bus.bout); end
`ifdef SERIAL_SUB_OVF_EN
        tests_run++;
        if (bus.ovf !== model_ovf(9, 3, 0)) begin tests_failed++; $display("FAIL lat_ovf got %b want %0d", bus.ovf, model_ovf(9, 3, 0)); end
`endif
        prev_d = 6;
        tick();
        tests_run++;
        if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL lat_done_pulse got %b want 0", bus.done); end
    endtask

    task automatic run_checked(input string tag, input int a, input int b, input int bin);
        bit ok;
        issue(a, b, bin);
        wait_done(ok);
        tests_run += 3;
        if (!ok) begin tests_failed++; $display("FAIL %s_timeout a=%0d b=%0d got no done want done", tag, a, b); end
        if (bus.d !== model_d(a, b, bin)) begin
            tests_failed++; $display("FAIL %s_d a=%0d b=%0d bin=%0d got %h want %h", tag, a, b, bin, bus.d, model_d(a, b, bin));
        end
        if (bus.bout !== model_bout(a, b, bin)) begin
            tests_failed++; $display("FAIL %s_bout a=%0d b=%0d bin=%0d got %b want %0d", tag, a, b, bin, bus.bout, model_bout(a, b, bin));
        end
`ifdef SERIAL_SUB_OVF_EN
        tests_run++;
        if (bus.ovf !== model_ovf(a, b, bin)) begin
            tests_failed++; $display("FAIL %s_ovf a=%0d b=%0d bin=%0d got %b want %0d", tag, a, b, bin, bus.ovf, model_ovf(a, b, bin));
        end
`endif
        prev_d = model_d(a, b, bin);
        tick();
    endtask

    task automatic test_arith();
        int va[8] = '{3, 0, 8, 7, 5, 15, 15, 0};
        int vb[8] = '{9, 0, 1, 1, 5, 0, 0, 15};
        int vc[8] = '{0, 1, 0, 0, 0, 0, 1, 1};
        for (int i = 0; i < 8; i++) run_checked("dir", va[i], vb[i], vc[i]);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_checked("rnd", int'($urandom_range(MASK, 0)), int'($urandom_range(MASK, 0)),
                        int'($urandom_range(1, 0)));
        end
    endtask

    task automatic test_start_ignored();
        int dones = 0;
        int got_d = -1;
        int got_b = -1;
        issue(5, 2, 0);
        bus.a = 4'hF;
        bus.b = 4'hF;
        bus.bin = 1'b1;
        bus.start = 1'b1;
        tests_run++;
        if (bus.d !== prev_d[W-1:0]) begin tests_failed++; $display("FAIL ign_d_hold got %h want %h", bus.d, prev_d[W-1:0]); end
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (bus.done === 1'b1) begin
                dones++;
                got_d = int'(bus.d);
                got_b = int'(bus.bout);
            end
            tick();
        end
        tests_run += 3;
        if (dones != 1) begin tests_failed++; $display("FAIL ign_done_count got %0d want 1", dones); end
        if (got_d != 3) begin tests_failed++; $display("FAIL ign_d got %0d want 3", got_d); end
        if (got_b != 0) begin tests_failed++; $display("FAIL ign_bout got %0d want 0", got_b); end
        prev_d = 3;
    endtask

    task automatic test_reset_mid_run();
        int dones = 0;
        issue(9, 3, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run += 4;
        if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL abort_done got %b want 0", bus.done); end
        if (bus.d !== 4'h0) begin tests_failed++; $display("FAIL abort_d got %h want 0", bus.d); end
        if (bus.bout !== 1'b0) begin tests_failed++; $display("FAIL abort_bout got %b want 0", bus.bout); end
        for (int i = 0; i < 8; i++) begin
            if (bus.done === 1'b1) dones++;
            tick();
        end
        tests_run++;
        if (dones != 0) begin tests_failed++; $display("FAIL abort_no_done got %0d pulses want 0", dones); end
        prev_d = 0;
        run_checked("post_abort", 6, 4, 1);
    endtask

    task automatic test_back_to_back();
        int pend[$];
        int k, a, b, c, last_cyc, issued;
        bit ok;
        last_cyc = 0;
        bus.a = 4'h0;
        bus.b = 4'h0;
        bus.bin = 1'b0;
        bus.start = 1'b1;
        pend.push_back(0);
        issued = 1;
        tick();
        for (int n = 0; n < 512; n++) begin
            wait_done(ok);
            if (!ok) begin
                tests_run++; tests_failed++;
                $display("FAIL b2b_timeout op %0d got no done want done", n);
                break;
            end
            if (n > 0) begin
                tests_run++;
                if (cyc - last_cyc != W + 2) begin
                    tests_failed++; $display("FAIL b2b_spacing op %0d got %0d want %0d", n, cyc - last_cyc, W + 2);
                end
            end
            last_cyc = cyc;
            k = pend.pop_front();
            a = (k >> 5) & MASK;
            b = (k >> 1) & MASK;
            c = k & 1;
            tests_run += 2;
            if (bus.d !== model_d(a, b, c)) begin
                tests_failed++; $display("FAIL b2b_d a=%0d b=%0d bin=%0d got %h want %h", a, b, c, bus.d, model_d(a, b, c));
            end
            if (bus.bout !== model_bout(a, b, c)) begin
                tests_failed++; $display("FAIL b2b_bout a=%0d b=%0d bin=%0d got %b want %0d", a, b, c, bus.bout, model_bout(a, b, c));
            end
`ifdef SERIAL_SUB_OVF_EN
            tests_run++;
            if (bus.ovf !== model_ovf(a, b, c)) begin
                tests_failed++; $display("FAIL b2b_ovf a=%0d b=%0d bin=%0d got %b want %0d", a, b, c, bus.ovf, model_ovf(a, b, c));
            end
`endif
            if (issued < 512) begin
                bus.a = issued[8:5];
                bus.b = issued[4:1];
                bus.bin = issued[0];
                pend.push_back(issued);
                issued++;
            end
            tick();
        end
        bus.start = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.bin = 1'b0;
        test_reset();
        test_latency();
        test_arith();
        test_random();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
